// File: rtl/pe_maxpool2.sv
// pe_maxpool2 -- 2x2 stride-2 max-pooling stage downstream of the PE.
//
// Consumes a raster-order, LINES-wide stream of CL_IN-lane pixels. Each lane
// is an N-bit two's-complement value. Emits one pooled pixel per 2x2 window.
// Storage is a hold register for the even-column pixel and a half-width line
// buffer. The line buffer keeps the even-row pair maxima.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   d_in      input pixel, lane c = d_in[c*N +: N]
//   en_in     d_in valid this cycle
//   sof_in    start of frame (qualified by en_in): pixel is row 0, col 0
//   d_ch_in   channel enable mask, sampled on the emitting pixel
//   d_out     pooled pixel (registered; masked lanes read 0)
//   en_out    one-cycle pulse, d_out valid
//   d_ch_out  channel mask accompanying d_out
module pe_maxpool2 #(
  parameter int LINES = 16,
  parameter int CL_IN = 4,
  parameter int N     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CL_IN*N-1:0] d_in,
  input  logic               en_in,
  input  logic               sof_in,
  input  logic [CL_IN-1:0]   d_ch_in,
  output logic [CL_IN*N-1:0] d_out,
  output logic               en_out,
  output logic [CL_IN-1:0]   d_ch_out
);

  localparam int W     = CL_IN * N;
  localparam int COL_W = (LINES > 2) ? $clog2(LINES) : 1;
  localparam int AW    = (COL_W > 1) ? COL_W - 1 : 1;

  logic [COL_W-1:0] col;
  logic             row_odd;
  logic [W-1:0]     hold;
  logic [W-1:0]     linebuf [0:(1 << AW) - 1];

  logic [AW-1:0]    lb_addr;
  logic [W-1:0]     lb_rd;
  logic [W-1:0]     pair_max;
  logic [W-1:0]     pool_max;
  logic             lb_we;
  logic             emit;
  logic             col_last;

  function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign lb_addr  = AW'(col >> 1);
  assign lb_rd    = linebuf[lb_addr];
  assign col_last = (col == COL_W'(LINES - 1));

  // A sof pixel is always treated as col 0 of an even row. It therefore
  // never writes the line buffer and never emits.
  assign lb_we = en_in && !rst && !sof_in && col[0] && !row_odd;
  assign emit  = en_in && !sof_in && col[0] && row_odd;

  always_comb begin
    pair_max = '0;
    pool_max = '0;
    for (int c = 0; c < CL_IN; c++) begin
      pair_max[c*N +: N] = smax(hold[c*N +: N], d_in[c*N +: N]);
      pool_max[c*N +: N] = d_ch_in[c] ? smax(lb_rd[c*N +: N], pair_max[c*N +: N]) : '0;
    end
  end

  // Every entry is written on an even row before the next odd row reads it,
  // so the buffer has no reset.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_addr] <= pair_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row_odd  <= 1'b0;
      hold     <= '0;
      d_out    <= '0;
      en_out   <= 1'b0;
      d_ch_out <= '0;
    end else begin
      en_out <= 1'b0;
      if (en_in) begin
        if (sof_in) begin
          hold    <= d_in;
          col     <= COL_W'(1);
          row_odd <= 1'b0;
        end else begin
          if (!col[0]) hold <= d_in;
          if (emit) begin
            d_out    <= pool_max;
            en_out   <= 1'b1;
            d_ch_out <= d_ch_in;
          end
          if (col_last) begin
            col     <= '0;
            row_odd <= ~row_odd;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_maxpool2.sv
module tb_pe_maxpool2;

  localparam int LINES = 16;
  localparam int CL    = 4;
  localparam int N     = 2;
  localparam int W     = CL * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  d_in = '0;
  logic          en_in = 1'b0;
  logic          sof_in = 1'b0;
  logic [CL-1:0] d_ch_in = '0;
  logic [W-1:0]  d_out;
  logic          en_out;
  logic [CL-1:0] d_ch_out;

  pe_maxpool2 #(.LINES(LINES), .CL_IN(CL), .N(N)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .sof_in(sof_in),
    .d_ch_in(d_ch_in), .d_out(d_out), .en_out(en_out), .d_ch_out(d_ch_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_pulse = 0;

  // literal pins applied to every pulse while lit_on is set
  logic          lit_on = 1'b0;
  logic [W-1:0]  lit_d = '0;
  logic [CL-1:0] lit_ch = '0;

  // ---------------- behavioural model ----------------
  // Keeps the raw pixels of the current even row and odd row, and pools the
  // four pixels of a window directly when its last pixel arrives.
  logic [W-1:0]  ev_row [LINES];
  logic [W-1:0]  od_row [LINES];
  int            m_col = 0;
  bit            m_odd = 0;
  logic          exp_en = 1'b0;
  logic [W-1:0]  exp_d = '0;
  logic [CL-1:0] exp_ch = '0;

  function automatic logic [W-1:0] pool4(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [W-1:0] d,
                                         input logic [CL-1:0] m);
    logic [W-1:0] r;
    logic [N-1:0] la, lb, lc, ld;
    int best;
    r = '0;
    for (int l = 0; l < CL; l++) begin
      la = a[l*N +: N]; lb = b[l*N +: N]; lc = c[l*N +: N]; ld = d[l*N +: N];
      best = int'($signed(la));
      if (int'($signed(lb)) > best) best = int'($signed(lb));
      if (int'($signed(lc)) > best) best = int'($signed(lc));
      if (int'($signed(ld)) > best) best = int'($signed(ld));
      if (m[l]) r[l*N +: N] = N'(best);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_col = 0; m_odd = 0; exp_en = 1'b0; exp_d = '0; exp_ch = '0;
    end else begin
      exp_en = 1'b0;
      if (en_in) begin
        if (sof_in) begin m_col = 0; m_odd = 0; end
        if (!m_odd) ev_row[m_col] = d_in; else od_row[m_col] = d_in;
        if (m_odd && (m_col % 2 == 1)) begin
          exp_d  = pool4(ev_row[m_col-1], ev_row[m_col], od_row[m_col-1], od_row[m_col], d_ch_in);
          exp_en = 1'b1;
          exp_ch = d_ch_in;
        end
        m_col++;
        if (m_col == LINES) begin m_col = 0; m_odd = !m_odd; end
      end
    end
  end

  // ---------------- compare process ----------------
  logic prev_en = 1'b0;
  always @(posedge clk) begin
    #2;
    tests++;
    if (en_out !== exp_en) begin
      fails++; $display("FAIL en_out: got %b want %b at %0t", en_out, exp_en, $time);
    end
    tests++;
    if (d_out !== exp_d) begin
      fails++; $display("FAIL d_out: got %h want %h at %0t", d_out, exp_d, $time);
    end
    tests++;
    if (d_ch_out !== exp_ch) begin
      fails++; $display("FAIL d_ch_out: got %b want %b at %0t", d_ch_out, exp_ch, $time);
    end
    if (en_out === 1'b1) begin
      n_pulse++;
      tests++;
      if (prev_en) begin
        fails++; $display("FAIL back_to_back_en: got 2 pulses in a row at %0t", $time);
      end
      if (lit_on) begin
        tests++;
        if (d_out !== lit_d || d_ch_out !== lit_ch) begin
          fails++;
          $display("FAIL literal_out: got d=%h ch=%b want d=%h ch=%b at %0t",
                   d_out, d_ch_out, lit_d, lit_ch, $time);
        end
      end
    end
    prev_en = (en_out === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic px(input logic [W-1:0] d, input logic en, input logic sof,
                    input logic [CL-1:0] ch, input logic r);
    @(negedge clk);
    d_in = d; en_in = en; sof_in = sof; d_ch_in = ch; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(W'($urandom), 1'b0, 1'b0, CL'($urandom), 1'b0);
  endtask

  // Feeds ncols pixels: even cols get ev, odd cols get od with mask msk.
  // With gap set, an idle cycle (carrying a stray sof) precedes every pixel.
  task automatic row(input logic [W-1:0] ev, input logic [W-1:0] od, input logic [CL-1:0] msk,
                     input bit gap, input bit sof_first, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      if (gap) px(W'($urandom), 1'b0, 1'b1, CL'($urandom), 1'b0);
      if (c % 2 == 1) px(od, 1'b1, 1'b0, msk, 1'b0);
      else            px(ev, 1'b1, sof_first && (c == 0), CL'($urandom), 1'b0);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++; $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  int mark;

  initial begin
    // 1. reset with en_in high
    px(8'hC3, 1'b1, 1'b0, 4'hF, 1'b1);
    px(8'h3C, 1'b1, 1'b1, 4'hF, 1'b1);
    n_pulse = 0;
    for (int i = 0; i < LINES; i++) px(W'($urandom), 1'b1, 1'b0, CL'($urandom), 1'b0);
    idle(2);
    chk_int("post_reset_no_pulse", n_pulse, 0);

    // 2. basic pooling
    lit_on = 1; lit_d = 8'h55; lit_ch = 4'hF; n_pulse = 0;
    row(8'h00, 8'h00, 4'hF, 0, 1, LINES);
    row(8'h55, 8'hAA, 4'hF, 0, 0, LINES);
    idle(3);
    chk_int("basic_pulses", n_pulse, 8);

    // 3. signed negatives
    lit_d = 8'hFF; n_pulse = 0;
    row(8'hAA, 8'hAA, 4'hF, 0, 1, LINES);
    row(8'hFF, 8'hAA, 4'hF, 0, 0, LINES);
    idle(3);
    chk_int("negative_pulses", n_pulse, 8);

    // 4. gapped input
    lit_d = 8'h55; n_pulse = 0;
    row(8'h00, 8'h00, 4'hF, 1, 1, LINES);
    row(8'h55, 8'hAA, 4'hF, 1, 0, LINES);
    idle(3);
    chk_int("gapped_pulses", n_pulse, 8);

    // 5a. channel mask
    lit_d = 8'h45; lit_ch = 4'b1011; n_pulse = 0;
    row(8'h00, 8'h00, 4'b1011, 0, 1, LINES);
    row(8'h55, 8'hAA, 4'b1011, 0, 0, LINES);
    idle(3);
    chk_int("mask_pulses", n_pulse, 8);

    // 5b. sof at row-1 col 6 restarts the frame
    lit_d = 8'h55; lit_ch = 4'hF; n_pulse = 0;
    row(8'h00, 8'h00, 4'hF, 0, 1, LINES);
    row(8'h55, 8'hAA, 4'hF, 0, 0, 6);
    row(8'h00, 8'h00, 4'hF, 0, 1, LINES);
    row(8'h55, 8'hAA, 4'hF, 0, 0, LINES);
    idle(3);
    chk_int("sof_restart_pulses", n_pulse, 11);

    // 6. reset mid-row at row-1 col 9, then a fresh frame without sof
    n_pulse = 0;
    row(8'h00, 8'h00, 4'hF, 0, 1, LINES);
    row(8'h55, 8'hAA, 4'hF, 0, 0, 9);
    px(8'hAA, 1'b1, 1'b0, 4'hF, 1'b1);
    idle(2);
    chk_int("pre_reset_pulses", n_pulse, 4);
    mark = n_pulse;
    row(8'h00, 8'h00, 4'hF, 0, 0, LINES);
    idle(2);
    chk_int("fresh_row0_no_pulse", n_pulse - mark, 0);
    row(8'h55, 8'hAA, 4'hF, 0, 0, LINES);
    idle(3);
    chk_int("fresh_frame_pulses", n_pulse - mark, 8);
    lit_on = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      px(W'($urandom), ($urandom % 4) != 0, ($urandom % 50) == 0, CL'($urandom),
         ($urandom % 300) == 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_maxpool2.md
# pe_maxpool2

2x2 stride-2 max-pooling stage placed directly downstream of the PE. It consumes the PE's per-channel output stream (CL_IN lanes of N-bit two's-complement values, one pixel per enable) in raster order over a LINES-wide frame. It emits one pooled pixel per 2x2 window, so the output row length is LINES/2. It buffers one half-width row of partial maxima per channel and needs no backpressure.

## Interface
Parameters:
- LINES, 16, input row length in pixels; must be even and >= 2
- CL_IN, 4, number of parallel channels (lanes)
- N, 2, lane data width; two's complement

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- d_in  in  CL_IN*N  input pixel; lane c is d_in[c*N +: N]
- en_in  in  1  d_in valid this cycle (the PE's en_out)
- sof_in  in  1  start of frame; qualified by en_in; marks the pixel at row 0, column 0
- d_ch_in  in  CL_IN  channel enable mask (the PE's d_ch_out)
- d_out  out  CL_IN*N  pooled pixel, registered
- en_out  out  1  one-cycle pulse; d_out valid
- d_ch_out  out  CL_IN  channel mask accompanying d_out

## Operation
- **State**
  - col counter: 0..LINES-1. Increments on each en_in and wraps to 0 after LINES-1.
  - row parity bit: toggles on each col wrap.
  - hold register: CL_IN*N wide.
  - line buffer: LINES/2 entries of CL_IN*N, addressed by col>>1.
- **Per accepted pixel (en_in=1)**, with all max operations signed and per lane:
  - Even col, either row parity: hold <= d_in.
  - Odd col, even row: linebuf[col>>1] <= max(hold, d_in).
  - Odd col, odd row: d_out <= max(linebuf[col>>1], hold, d_in) and en_out <= 1. d_ch_out <= d_ch_in as sampled on that pixel.
- **Channel masking.** Lanes whose d_ch_in bit is 0 on the emitting pixel drive 0 on d_out. Masks on non-emitting pixels are ignored.
- **sof_in with en_in.** The pixel is processed as col 0, even row, regardless of counter state. Counters advance from there and any partial window is discarded. sof_in without en_in is ignored.
- **en_in=0.** Counters, hold and line buffer are unchanged. d_out and d_ch_out hold their last value; en_out=0.
- **Frame height** is unbounded. Pooling pairs rows (0,1), (2,3), and so on. An odd trailing row produces no output.
- **Line buffer** is not reset. Every entry is written on an even row before it is read on the next odd row.

## Timing
- **Reset values:** d_out=0, en_out=0, d_ch_out=0, col=0, row parity=0 (even), hold=0.
- **Latency:** en_out is high in the cycle after the clock edge that accepts the odd-row, odd-col pixel, i.e. 1-cycle registered latency.
- **Throughput:** at most one output every 2 accepted pixels within an odd row. LINES/2 outputs per row pair; en_out is never high two cycles in a row.
- **Reset mid-row:** state returns to reset values on the next edge. The next en_in pixel is treated as col 0, even row. No en_out is produced from pre-reset data.
- **rst and en_in together:** rst wins; the pixel is dropped.
- **sof_in on a pixel that would otherwise emit:** no emit occurs; the pixel is processed as col 0.

## Test plan
1. **Reset.** Hold rst for 2 cycles with en_in=1.
   - Required: d_out=0, en_out=0, d_ch_out=0 throughout; no en_out in the first LINES cycles after release.
2. **Basic pooling**, d_ch_in=4'b1111, sof_in on the first pixel, 2 rows of 16 pixels.
   - Row 0: all lanes 0. Row 1: even cols all lanes 2'b01, odd cols 2'b10.
   - Required: 8 en_out pulses, at the cycles after row-1 cols 1,3,...,15; each d_out=8'h55.
3. **Signed negatives.** Row 0 all 2'b10 (-2). Row 1 alternating 2'b11 (-1) / 2'b10.
   - Required: every d_out lane = 2'b11.
4. **Gapped input.** Same stimulus as scenario 2 with en_in=0 inserted on every other cycle.
   - Required: identical 8 outputs and values; en_out only after accepted odd-col pixels.
5. **Channel mask and sof.**
   - With d_ch_in=4'b1011 on emitting pixels of scenario 2: d_out=8'h45, d_ch_out=4'b1011.
   - Asserting sof_in at row-1 col 6 suppresses the remaining row-1 outputs. The new frame then pools correctly.
6. **Reset mid-row.** Assert rst at row-1 col 9 of scenario 2, then feed a fresh 2-row frame without sof_in.
   - Required: no en_out before the fresh frame's row 1; then 8 correct outputs.
